riscv_nn_apu_wb_buffer: RTL and testbench
=========================================

RISCV_NN_APU_WB_BUFFER -- requirements
Module: riscv_nn_apu_wb_buffer

Interface
REQ-001 Parameter DEPTH, default 3, number of result entries; legal range 2..4.
REQ-002 Parameter DATA_W, default 32, APU result width.
REQ-003 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_i  in  1  reset; synchronous, active-high.
REQ-005 apu_valid_i  in  1  APU result valid; the dispatcher always signals ready, so there is no backpressure.
REQ-006 apu_result_i  in  DATA_W  APU result data.
REQ-007 apu_flags_i  in  5  APU FP status flags (NV, DZ, OF, UF, NX).
REQ-008 apu_waddr_i  in  6  destination register from the dispatcher's writeback address output; bit 5 selects the FP register file.
REQ-009 lsu_wb_valid_i  in  1  LSU owns register-file write port B this cycle.
REQ-010 wb_we_o  out  1  port-B write enable for the APU result.
REQ-011 wb_waddr_o  out  6  port-B write address.
REQ-012 wb_wdata_o  out  DATA_W  port-B write data.
REQ-013 fflags_we_o  out  1  accumulate flags into fcsr; asserted together with wb_we_o.
REQ-014 fflags_o  out  5  flags of the entry being written.
REQ-015 read_regs_i  in  3x6  decode-stage source registers.
REQ-016 read_regs_valid_i  in  3  source-register valids.
REQ-017 read_dep_o  out  1  a source register is pending in the buffer.
REQ-018 count_o  out  clog2(DEPTH+1)  occupancy.
REQ-019 pending_o  out  1  count_o != 0.
REQ-020 overflow_o  out  1  sticky overflow error.

Function
REQ-021 Storage is a circular FIFO with head and tail pointers, both wrapping from DEPTH-1 to 0; each entry holds {waddr, result, flags}.
REQ-022 Port free = !lsu_wb_valid_i; LSU always has priority and its write is never delayed.
REQ-023 Bypass: when the FIFO is empty, apu_valid_i=1 and the port is free, the input is written in the same cycle (zero latency) and nothing is stored.
REQ-024 Ordering: when the FIFO is non-empty, an incoming result is always pushed at the tail, never bypassed, even if the port is free.
REQ-025 Drain: when the FIFO is non-empty and the port is free, the head entry drives wb_* and fflags_o, and the head pointer advances at the clock edge.
REQ-026 Push and pop in the same cycle are both performed and count is unchanged; this includes the full case.
REQ-027 Push when full and no pop: the result is dropped, storage is unchanged, and overflow_o is set and held until reset.
REQ-028 When wb_we_o=0, wb_waddr_o, wb_wdata_o and fflags_o are 0.
REQ-029 read_dep_o = any valid source matching the waddr of any occupied entry, or matching apu_waddr_i when apu_valid_i=1 and the input is being stored (not bypassed).
REQ-030 read_dep_o excludes the head entry in the cycle it is written; the register-file write-through handles that case.
REQ-031 Dependency compare uses all 6 bits, so an FP register never matches an integer register.
REQ-032 An apu_valid_i in the reset cycle is ignored.

Reset
REQ-033 While rst_i=1, the following are cleared: head, tail, count, overflow_o and all entry waddr fields.
REQ-034 During reset all outputs are 0.
REQ-035 Reset mid-operation discards all buffered results with no writeback.

Structure
REQ-036 Shared package riscv_nn_apu_pkg holds:
  - the entry struct type;
  - the flags width constant (5);
  - the register-address width constant (6).
REQ-037 Single flat module; no sub-modules are required (the FIFO is inline).

Verification
REQ-038 Bypass: FIFO empty, LSU idle, apu_valid_i=1, waddr=0x05, result=0xDEADBEEF -> same cycle wb_we_o=1, wb_waddr_o=0x05, wb_wdata_o=0xDEADBEEF; count_o stays 0.
REQ-039 Blocked: lsu_wb_valid_i=1 for 3 cycles with results A (0x01) and B (0x02) arriving in cycles 1 and 2 -> count_o=2 and read_dep_o=1 for source 0x02; after the LSU releases, A is written, then B on the next cycle.
REQ-040 Ordering: one entry buffered, port free, new result C arrives -> head written, C pushed, count_o stays 1; C is written the following cycle.
REQ-041 Overflow: DEPTH=3, LSU busy, 4 results -> count_o=3 and overflow_o=1, held after the LSU releases; only 3 writebacks occur.
REQ-042 Full with simultaneous push/pop: count stays 3 and the pointers wrap correctly; verify over 10 entries that writeback order equals arrival order.
REQ-043 Reset mid-operation: count_o=2, then rst_i for one cycle -> count_o=0, pending_o=0, no wb_we_o; a new result afterwards takes the bypass path.

Source files
------------

// File: rtl/riscv_nn_apu_pkg.sv
// Shared APU writeback types: entry layout, address/flag widths and the
// source-register dependency compare used by the writeback buffer.
package riscv_nn_apu_pkg;

    localparam int APU_FLAGS_W = 5;
    localparam int APU_ADDR_W  = 6;
    localparam int APU_DATA_W  = 32;
    localparam int N_READ_REGS = 3;

    typedef struct packed {
        logic [APU_ADDR_W-1:0]  waddr;
        logic [APU_DATA_W-1:0]  result;
        logic [APU_FLAGS_W-1:0] flags;
    } apu_wb_entry_t;

    // Full 6-bit compare keeps FP and integer registers apart.
    function automatic logic src_match(
        input logic [N_READ_REGS*APU_ADDR_W-1:0] regs,
        input logic [N_READ_REGS-1:0]            regs_valid,
        input logic [APU_ADDR_W-1:0]             addr
    );
        logic hit;
        hit = 1'b0;
        for (int j = 0; j < N_READ_REGS; j++) begin
            if (regs_valid[j] && (regs[j*APU_ADDR_W +: APU_ADDR_W] == addr)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/riscv_nn_apu_wb_buffer.sv
// APU result writeback buffer: bypasses to register-file port B when free,
// otherwise queues results in order behind LSU writes.
module riscv_nn_apu_wb_buffer
    import riscv_nn_apu_pkg::*;
#(
    parameter int  DEPTH  = 3,
    parameter int  DATA_W = APU_DATA_W,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              apu_valid_i,
    input  logic [DATA_W-1:0]                 apu_result_i,
    input  logic [APU_FLAGS_W-1:0]            apu_flags_i,
    input  logic [APU_ADDR_W-1:0]             apu_waddr_i,
    input  logic                              lsu_wb_valid_i,
    output logic                              wb_we_o,
    output logic [APU_ADDR_W-1:0]             wb_waddr_o,
    output logic [DATA_W-1:0]                 wb_wdata_o,
    output logic                              fflags_we_o,
    output logic [APU_FLAGS_W-1:0]            fflags_o,
    input  logic [N_READ_REGS*APU_ADDR_W-1:0] read_regs_i,
    input  logic [N_READ_REGS-1:0]            read_regs_valid_i,
    output logic                              read_dep_o,
    output logic [CNT_W-1:0]                  count_o,
    output logic                              pending_o,
    output logic                              overflow_o
);

    localparam int PTR_W = $clog2(DEPTH);

    apu_wb_entry_t    mem [DEPTH];
    logic [PTR_W-1:0] head_q, tail_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic             port_free, empty, full;
    logic             bypass, pop, push_req, push, drop;
    apu_wb_entry_t    head_entry, in_entry;
    logic             read_dep;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Reset forces the port "busy" so nothing is written or stored that cycle.
    assign port_free = !lsu_wb_valid_i && !rst_i;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign bypass    = empty && apu_valid_i && port_free;
    assign pop       = !empty && port_free;
    assign push_req  = apu_valid_i && !rst_i && !bypass;
    assign push      = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    assign head_entry = mem[head_q];
    assign in_entry   = '{waddr: apu_waddr_i, result: apu_result_i, flags: apu_flags_i};

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        int unsigned idx;
        read_dep = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = int'(head_q) + k;
            if (idx >= DEPTH) begin
                idx = idx - DEPTH;
            end
            // The head being written this cycle is covered by register-file write-through.
            if ((CNT_W'(k) < count_q) && !(k == 0 && pop) &&
                src_match(read_regs_i, read_regs_valid_i, mem[idx[PTR_W-1:0]].waddr)) begin
                read_dep = 1'b1;
            end
        end
        if (push && src_match(read_regs_i, read_regs_valid_i, apu_waddr_i)) begin
            read_dep = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            // NOTE: only the address fields are reset; result/flags are never read while unoccupied.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i].waddr <= '0;
            end
        end else begin
            if (push) begin
                mem[tail_q] <= in_entry;
                tail_q      <= ptr_inc(tail_q);
            end
            if (pop) begin
                head_q <= ptr_inc(head_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign wb_we_o     = bypass || pop;
    assign fflags_we_o = wb_we_o;
    assign wb_waddr_o  = bypass ? apu_waddr_i  : (pop ? head_entry.waddr  : '0);
    assign wb_wdata_o  = bypass ? apu_result_i : (pop ? head_entry.result : '0);
    assign fflags_o    = bypass ? apu_flags_i  : (pop ? head_entry.flags  : '0);

    assign read_dep_o = read_dep && !rst_i;
    assign count_o    = rst_i ? '0 : count_q;
    assign pending_o  = !rst_i && !empty;
    assign overflow_o = !rst_i && overflow_q;

endmodule

// File: tb/tb_riscv_nn_apu_wb_buffer.sv
// Directed bench for the APU writeback buffer: reset, bypass, LSU blocking,
// ordering, overflow, full push/pop wrap and mid-operation reset.
module tb_riscv_nn_apu_wb_buffer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        apu_valid_i;
    logic [31:0] apu_result_i;
    logic [4:0]  apu_flags_i;
    logic [5:0]  apu_waddr_i;
    logic        lsu_wb_valid_i;
    logic        wb_we_o;
    logic [5:0]  wb_waddr_o;
    logic [31:0] wb_wdata_o;
    logic        fflags_we_o;
    logic [4:0]  fflags_o;
    logic [17:0] read_regs_i;
    logic [2:0]  read_regs_valid_i;
    logic        read_dep_o;
    logic [1:0]  count_o;
    logic        pending_o;
    logic        overflow_o;

    int n_checks = 0;
    int n_errors = 0;

    riscv_nn_apu_wb_buffer #(.DEPTH(3), .DATA_W(32)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .apu_valid_i       (apu_valid_i),
        .apu_result_i      (apu_result_i),
        .apu_flags_i       (apu_flags_i),
        .apu_waddr_i       (apu_waddr_i),
        .lsu_wb_valid_i    (lsu_wb_valid_i),
        .wb_we_o           (wb_we_o),
        .wb_waddr_o        (wb_waddr_o),
        .wb_wdata_o        (wb_wdata_o),
        .fflags_we_o       (fflags_we_o),
        .fflags_o          (fflags_o),
        .read_regs_i       (read_regs_i),
        .read_regs_valid_i (read_regs_valid_i),
        .read_dep_o        (read_dep_o),
        .count_o           (count_o),
        .pending_o         (pending_o),
        .overflow_o        (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic srcs(input logic [5:0] r0, input logic [5:0] r1, input logic [5:0] r2,
                        input logic [2:0] vld);
        read_regs_i       = {r2, r1, r0};
        read_regs_valid_i = vld;
        #1;
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit later.
    task automatic step(input logic v, input logic [5:0] a, input logic [31:0] d,
                        input logic [4:0] f, input logic lsu);
        @(negedge clk_i);
        apu_valid_i    = v;
        apu_waddr_i    = a;
        apu_result_i   = d;
        apu_flags_i    = f;
        lsu_wb_valid_i = lsu;
        #1;
    endtask

    task automatic check_wb(input string tag, input logic we, input logic [5:0] a,
                            input logic [31:0] d, input logic [4:0] f);
        check({tag, "_we"},     32'(wb_we_o),     32'(we));
        check({tag, "_fwe"},    32'(fflags_we_o), 32'(we));
        check({tag, "_waddr"},  32'(wb_waddr_o),  32'(a));
        check({tag, "_wdata"},  wb_wdata_o,       d);
        check({tag, "_fflags"}, 32'(fflags_o),    32'(f));
    endtask

    initial begin
        rst_i = 1'b1;
        apu_valid_i = 1'b0; apu_result_i = '0; apu_flags_i = '0; apu_waddr_i = '0;
        lsu_wb_valid_i = 1'b0; read_regs_i = '0; read_regs_valid_i = '0;

        // Reset with a result offered: outputs stay 0 and the result is ignored.
        step(1'b1, 6'h11, 32'h1111_1111, 5'h1f, 1'b0);
        srcs(6'h11, 6'h00, 6'h00, 3'b001);
        check_wb("rst", 1'b0, 6'h00, 32'h0, 5'h00);
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_pending", 32'(pending_o), 32'd0);
        check("rst_overflow", 32'(overflow_o), 32'd0);
        check("rst_dep", 32'(read_dep_o), 32'd0);
        rst_i = 1'b0;
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("rst_ignored_count", 32'(count_o), 32'd0);
        check_wb("idle", 1'b0, 6'h00, 32'h0, 5'h00);

        // Bypass: written in the same cycle, nothing stored.
        step(1'b1, 6'h05, 32'hDEAD_BEEF, 5'h03, 1'b0);
        srcs(6'h05, 6'h00, 6'h00, 3'b001);
        check_wb("byp", 1'b1, 6'h05, 32'hDEAD_BEEF, 5'h03);
        check("byp_dep", 32'(read_dep_o), 32'd0);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("byp_count", 32'(count_o), 32'd0);
        check_wb("byp_after", 1'b0, 6'h00, 32'h0, 5'h00);

        // LSU blocks port B for three cycles while A and B arrive.
        step(1'b1, 6'h01, 32'h0000_000A, 5'h01, 1'b1);
        srcs(6'h01, 6'h00, 6'h00, 3'b001);
        check("blk_a_we", 32'(wb_we_o), 32'd0);
        check("blk_a_dep_in", 32'(read_dep_o), 32'd1);
        step(1'b1, 6'h02, 32'h0000_000B, 5'h02, 1'b1);
        check("blk_b_count", 32'(count_o), 32'd1);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b1);
        check("blk_count2", 32'(count_o), 32'd2);
        check("blk_pending", 32'(pending_o), 32'd1);
        srcs(6'h22, 6'h02, 6'h00, 3'b001);
        check("blk_fp_nomatch", 32'(read_dep_o), 32'd0);
        srcs(6'h22, 6'h02, 6'h00, 3'b011);
        check("blk_dep_b", 32'(read_dep_o), 32'd1);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check_wb("drain_a", 1'b1, 6'h01, 32'h0000_000A, 5'h01);
        srcs(6'h01, 6'h00, 6'h00, 3'b001);
        check("drain_a_head_excl", 32'(read_dep_o), 32'd0);
        srcs(6'h01, 6'h02, 6'h00, 3'b011);
        check("drain_a_dep_b", 32'(read_dep_o), 32'd1);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check_wb("drain_b", 1'b1, 6'h02, 32'h0000_000B, 5'h02);
        check("drain_b_count", 32'(count_o), 32'd1);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("drain_done_count", 32'(count_o), 32'd0);
        check("drain_done_we", 32'(wb_we_o), 32'd0);
        srcs(6'h00, 6'h00, 6'h00, 3'b000);

        // Ordering: with D buffered, C is queued behind it rather than bypassed.
        step(1'b1, 6'h03, 32'h0000_000D, 5'h04, 1'b1);
        step(1'b1, 6'h04, 32'h0000_000C, 5'h08, 1'b0);
        check_wb("ord_d", 1'b1, 6'h03, 32'h0000_000D, 5'h04);
        srcs(6'h04, 6'h00, 6'h00, 3'b001);
        check("ord_c_dep", 32'(read_dep_o), 32'd1);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("ord_count", 32'(count_o), 32'd1);
        check_wb("ord_c", 1'b1, 6'h04, 32'h0000_000C, 5'h08);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("ord_done", 32'(count_o), 32'd0);
        srcs(6'h00, 6'h00, 6'h00, 3'b000);

        // Overflow: four results into a depth-3 buffer while the LSU holds the port.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'(16 + i), 32'(32'h100 + i), 5'(i + 1), 1'b1);
        end
        step(1'b1, 6'h13, 32'h0000_0103, 5'h1f, 1'b1);
        check("ovf_full_count", 32'(count_o), 32'd3);
        srcs(6'h13, 6'h00, 6'h00, 3'b001);
        check("ovf_drop_dep", 32'(read_dep_o), 32'd0);
        srcs(6'h00, 6'h00, 6'h00, 3'b000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
            check("ovf_sticky", 32'(overflow_o), 32'd1);
            check("ovf_count", 32'(count_o), 32'(3 - i));
            check_wb("ovf_wb", 1'b1, 6'(16 + i), 32'(32'h100 + i), 5'(i + 1));
        end
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("ovf_only3_we", 32'(wb_we_o), 32'd0);
        check("ovf_end_count", 32'(count_o), 32'd0);
        check("ovf_end_sticky", 32'(overflow_o), 32'd1);

        // Full buffer with push and pop each cycle: ten entries leave in arrival order.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 6'(32 + i), 32'(32'h1000 + i), 5'h00, 1'b1);
        end
        for (int i = 3; i < 10; i++) begin
            step(1'b1, 6'(32 + i), 32'(32'h1000 + i), 5'h00, 1'b0);
            check("full_count", 32'(count_o), 32'd3);
            check("full_waddr", 32'(wb_waddr_o), 32'(32 + i - 3));
            check("full_wdata", wb_wdata_o, 32'(32'h1000 + i - 3));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
            check("full_drain_count", 32'(count_o), 32'(3 - i));
            check("full_drain_wdata", wb_wdata_o, 32'(32'h1007 + i));
        end
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("full_empty", 32'(count_o), 32'd0);

        // Reset mid-operation drops buffered results without writeback.
        step(1'b1, 6'h08, 32'h0000_0088, 5'h00, 1'b1);
        step(1'b1, 6'h09, 32'h0000_0099, 5'h00, 1'b1);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b1);
        check("mid_count2", 32'(count_o), 32'd2);
        rst_i = 1'b1;
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("mid_rst_we", 32'(wb_we_o), 32'd0);
        check("mid_rst_count", 32'(count_o), 32'd0);
        rst_i = 1'b0;
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("mid_post_count", 32'(count_o), 32'd0);
        check("mid_post_pending", 32'(pending_o), 32'd0);
        check("mid_post_overflow", 32'(overflow_o), 32'd0);
        check_wb("mid_post", 1'b0, 6'h00, 32'h0, 5'h00);
        step(1'b1, 6'h07, 32'h0000_0077, 5'h10, 1'b0);
        check_wb("mid_byp", 1'b1, 6'h07, 32'h0000_0077, 5'h10);
        step(1'b0, 6'h00, 32'h0, 5'h00, 1'b0);
        check("mid_byp_count", 32'(count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
